// File: rtl/mf_pll_pkg.sv
// Shared types and default sizing for the PLL sequencer / DPS controller.
package mf_pll_pkg;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    IDLE,
    STEP_EN,
    WAIT_LOW,
    WAIT_HIGH,
    DONE
  } state_t;

  localparam int unsigned DEF_CNT_W       = 5;
  localparam int unsigned DEF_STEP_W      = 8;
  localparam int unsigned DEF_RST_CYCLES  = 8;
  localparam int unsigned DEF_LOCK_FILTER = 16;
  localparam int unsigned DEF_TIMEOUT     = 1024;

endpackage

// File: rtl/mf_pll_dps_ctrl_sync_2ff.sv
// Two-flop synchronizer for the asynchronous PLL lock indication.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mf_pll_dps_ctrl.sv
// PLL reset/lock supervisor and dynamic phase-shift step sequencer.
module mf_pll_dps_ctrl
  import mf_pll_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned STEP_W      = DEF_STEP_W,
  parameter int unsigned RST_CYCLES  = DEF_RST_CYCLES,
  parameter int unsigned LOCK_FILTER = DEF_LOCK_FILTER,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CNT_W-1:0]  req_cntsel,
  input  logic              req_updn,
  input  logic [STEP_W-1:0] req_steps,
  input  logic              pll_locked,
  input  logic              pll_phase_done,
  output logic              pll_rst,
  output logic              pll_phase_en,
  output logic              pll_updn,
  output logic [CNT_W-1:0]  pll_cntsel,
  output logic              stable_locked,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned RW = $clog2(RST_CYCLES + 1);
  localparam int unsigned FW = $clog2(LOCK_FILTER + 1);
  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILTER - 1);
  // Fires on the wait cycle whose incremented count would reach TIMEOUT-1.
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 2);

  state_t            state;
  logic              lock_s;
  logic              in_req;
  logic              lock_lost;
  logic              en_second;
  logic [RW-1:0]     rst_cnt;
  logic [FW-1:0]     filt_cnt;
  logic [TW-1:0]     to_cnt;
  logic [STEP_W-1:0] remaining;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  always_comb begin
    in_req    = (state == STEP_EN) || (state == WAIT_LOW) || (state == WAIT_HIGH);
    lock_lost = !lock_s && (in_req || (state == IDLE) || (state == DONE));
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state         <= RESET_PLL;
      rst_cnt       <= '0;
      filt_cnt      <= '0;
      to_cnt        <= '0;
      en_second     <= 1'b0;
      remaining     <= '0;
      pll_rst       <= 1'b1;
      pll_phase_en  <= 1'b0;
      pll_updn      <= 1'b0;
      pll_cntsel    <= '0;
      req_ready     <= 1'b0;
      busy          <= 1'b1;
      stable_locked <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      done <= 1'b0;
      if (lock_lost) begin
        // Lock loss outranks timeout and request acceptance.
        state         <= RESET_PLL;
        rst_cnt       <= '0;
        filt_cnt      <= '0;
        pll_rst       <= 1'b1;
        pll_phase_en  <= 1'b0;
        req_ready     <= 1'b0;
        busy          <= 1'b1;
        stable_locked <= 1'b0;
        if (in_req) begin
          err  <= 1'b1;
          done <= 1'b1;
        end
      end else begin
        case (state)
          RESET_PLL: begin
            if (rst_cnt == RST_LAST) begin
              state   <= WAIT_LOCK;
              pll_rst <= 1'b0;
            end else begin
              rst_cnt <= rst_cnt + 1'b1;
            end
          end
          WAIT_LOCK: begin
            if (!lock_s) begin
              filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
              state         <= IDLE;
              stable_locked <= 1'b1;
              req_ready     <= 1'b1;
              busy          <= 1'b0;
            end else begin
              filt_cnt <= filt_cnt + 1'b1;
            end
          end
          IDLE: begin
            if (req_valid && req_ready) begin
              pll_cntsel <= req_cntsel;
              pll_updn   <= req_updn;
              remaining  <= req_steps;
              err        <= 1'b0;
              req_ready  <= 1'b0;
              busy       <= 1'b1;
              if (req_steps == '0) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state        <= STEP_EN;
                pll_phase_en <= 1'b1;
                en_second    <= 1'b0;
              end
            end
          end
          STEP_EN: begin
            to_cnt <= '0;
            if (!en_second) begin
              en_second <= 1'b1;
            end else begin
              pll_phase_en <= 1'b0;
              state        <= WAIT_LOW;
            end
          end
          WAIT_LOW, WAIT_HIGH: begin
            if (to_cnt == TO_LAST) begin
              err       <= 1'b1;
              done      <= 1'b1;
              remaining <= '0;
              state     <= DONE;
            end else begin
              to_cnt <= to_cnt + 1'b1;
              if (state == WAIT_LOW) begin
                if (!pll_phase_done) state <= WAIT_HIGH;
              end else if (pll_phase_done) begin
                remaining <= remaining - 1'b1;
                if (remaining == STEP_W'(1)) begin
                  state <= DONE;
                  done  <= 1'b1;
                end else begin
                  state        <= STEP_EN;
                  pll_phase_en <= 1'b1;
                  en_second    <= 1'b0;
                end
              end
            end
          end
          DONE: begin
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
          default: state <= RESET_PLL;
        endcase
      end
    end
  end

endmodule
